vpu_wb_issue: RTL and testbench
===============================

// Module: vpu_wb_issue
// PURPOSE
//  Writeback issue stage; sits directly downstream of the WB address queue FIFO.
//  Each cycle it can pop one destination address from that FIFO and one result word
//  from the execution pipe, and pair them into one operand-SRAM write request.
//  Counts the expected writebacks of a command and reports done_o to VPU_CONTROLLER.
// PARAMETERS
//  OPERAND_ADDR_WIDTH  VPU_PKG default  width of the destination operand address
//  DATA_WIDTH          VPU_PKG default  width of one result word / SRAM write
//  CNT_WIDTH           8                width of the writeback count per command
// PORTS
//  clk           in   1                   clock; single clock domain
//  rst_n         in   1                   asynchronous, active-low reset
//  start_i       in   1                   controller: begin command (IDLE only)
//  num_wb_i      in   CNT_WIDTH           writebacks expected; sampled with start_i
//  reset_cmd_i   in   1                   controller: abort/finish, return to IDLE
//  done_o        out  1                   all num_wb_i writes accepted by SRAM
//  addr_empty_i  in   1                   address FIFO empty
//  addr_rdata_i  in   OPERAND_ADDR_WIDTH  address FIFO head (show-ahead, valid if !empty)
//  addr_rden_o   out  1                   address FIFO pop
//  res_valid_i   in   1                   result word valid
//  res_data_i    in   DATA_WIDTH          result word
//  res_ready_o   out  1                   result word accepted
//  wr_valid_o    out  1                   SRAM write request valid
//  wr_addr_o     out  OPERAND_ADDR_WIDTH  SRAM write address
//  wr_data_o     out  DATA_WIDTH          SRAM write data
//  wr_ready_i    in   1                   SRAM accepts the write
//  stall_cnt_o   out  32                  pairing-stall cycles (see CONFIGURATION)
// BEHAVIOUR
//  Reset values: state = S_IDLE; done_o, wr_valid_o, addr_rden_o, res_ready_o = 0.
//  Reset values: wr_addr_o, wr_data_o, remaining counter, stall_cnt_o = 0.
//  FSM states: S_IDLE, S_RUN, S_DONE.
//  S_IDLE: on start_i, latch remaining = num_wb_i.
//   - num_wb_i == 0: go to S_DONE.
//   - otherwise: go to S_RUN.
//  S_RUN:
//   - slot_free = !wr_valid_o | wr_ready_i.
//   - res_ready_o = slot_free & !addr_empty_i & (remaining != 0).
//   - fire = res_ready_o & res_valid_i; addr_rden_o = fire (no pop without a data pair).
//   - On fire: output register <= {addr_rdata_i, res_data_i}; wr_valid_o = 1 next cycle.
//     remaining decrements.
//   - Latency: 1 cycle from fire to wr_valid_o.
//   - Back-to-back fires are allowed when wr_ready_i = 1 (full throughput, 1 write/cycle).
//   - wr_valid_o clears only on wr_ready_i with no new fire.
//   - wr_addr_o/wr_data_o stay stable while wr_valid_o & !wr_ready_i.
//   - Go to S_DONE when remaining == 0 and the last write is accepted (or no write is pending).
//  S_DONE: done_o = 1 (combinational from state); hold until reset_cmd_i.
//  reset_cmd_i has priority in every state:
//   - next state is S_IDLE; no fire in that cycle; wr_valid_o cleared next cycle
//     (a pending write is abandoned).
//   - Address FIFO contents are not flushed here; the queue flushes itself.
//  start_i is ignored outside S_IDLE.
//  Extra results or addresses beyond num_wb_i are never consumed.
//  Empty FIFO: wait, no pop; an underflow pop is impossible by construction.
// CONFIGURATION
//  Macro VPU_WB_ISSUE_PERF_CNT_EN.
//  Defined:
//   - stall_cnt_o counts S_RUN cycles with remaining != 0 and no fire.
//   - It saturates at 32'hFFFF_FFFF and clears on an accepted start_i.
//  Undefined: stall_cnt_o is tied to 0 and no counter flops are generated.
// STRUCTURE
//  VPU_PKG holds OPERAND_ADDR_WIDTH, DATA_WIDTH, REQ_FIFO_DEPTH_LG2.
//  VPU_PKG also holds the wb_state_t enum {S_IDLE, S_RUN, S_DONE}.
//  One sub-module, vpu_wb_out_reg: a valid/ready output register holding {addr, data}.
//  The FSM, the remaining counter and the perf counter live in vpu_wb_issue.
// TESTING
//  1. start num_wb=4; FIFO addrs 0x10..0x13; data A0..A3; wr_ready=1
//     -> 4 writes on consecutive cycles, (0x10,A0)..(0x13,A3); done_o 1 cycle after the last.
//  2. As 1, but wr_ready=0 for 3 cycles on write 2
//     -> addr/data held stable; no pop during the stall; in-order completion.
//  3. Data valid while FIFO is empty for 5 cycles -> no pop, res_ready_o=0; resumes when an address arrives.
//  4. num_wb=0 -> S_DONE next cycle, no writes; reset_cmd_i -> S_IDLE, done_o=0.
//  5. reset_cmd_i mid-run after 2 of 6 writes -> IDLE next cycle, wr_valid_o=0; new start works.
//  6. PERF_CNT_EN: 7 stall cycles -> stall_cnt_o=7; undefined build -> stall_cnt_o stays 0.

Source files
------------

// File: rtl/vpu_pkg.sv
// Shared VPU widths and the writeback-issue state encoding.
package vpu_pkg;

    localparam int OPERAND_ADDR_WIDTH = 10;
    localparam int DATA_WIDTH         = 32;
    localparam int REQ_FIFO_DEPTH_LG2 = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } wb_state_t;

endpackage

// File: rtl/vpu_wb_out_reg.sv
// Single-entry valid/ready output register carrying one {addr, data} write request.
module vpu_wb_out_reg #(
    parameter int AW = 10,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush_i,
    input  logic          load_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] data_i,
    input  logic          ready_i,
    output logic          valid_o,
    output logic [AW-1:0] addr_o,
    output logic [DW-1:0] data_o
);

    logic          valid_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] data_q;

    // Handshake: a write transfers on a cycle with valid_o & ready_i; while valid_o is
    // high and ready_i low the payload is held. Flush drops a pending write outright.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            if (flush_i) begin
                valid_q <= 1'b0;
            end else if (load_i) begin
                valid_q <= 1'b1;
            end else if (ready_i) begin
                valid_q <= 1'b0;
            end
            if (load_i && !flush_i) begin
                addr_q <= addr_i;
                data_q <= data_i;
            end
        end
    end

    assign valid_o = valid_q;
    assign addr_o  = addr_q;
    assign data_o  = data_q;

endmodule

// File: rtl/vpu_wb_issue.sv
// Writeback issue: pairs FIFO addresses with result words into operand-SRAM writes.
// Optional stall counter enabled by defining VPU_WB_ISSUE_PERF_CNT_EN.
module vpu_wb_issue #(
    parameter int OPERAND_ADDR_WIDTH = vpu_pkg::OPERAND_ADDR_WIDTH,
    parameter int DATA_WIDTH         = vpu_pkg::DATA_WIDTH,
    parameter int CNT_WIDTH          = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start_i,
    input  logic [CNT_WIDTH-1:0]          num_wb_i,
    input  logic                          reset_cmd_i,
    output logic                          done_o,
    input  logic                          addr_empty_i,
    input  logic [OPERAND_ADDR_WIDTH-1:0] addr_rdata_i,
    output logic                          addr_rden_o,
    input  logic                          res_valid_i,
    input  logic [DATA_WIDTH-1:0]         res_data_i,
    output logic                          res_ready_o,
    output logic                          wr_valid_o,
    output logic [OPERAND_ADDR_WIDTH-1:0] wr_addr_o,
    output logic [DATA_WIDTH-1:0]         wr_data_o,
    input  logic                          wr_ready_i,
    output logic [31:0]                   stall_cnt_o
);
    import vpu_pkg::*;

    wb_state_t            state_q;
    logic [CNT_WIDTH-1:0] remaining_q;
    logic                 running;
    logic                 slot_free;
    logic                 fire;

    assign running   = (state_q == S_RUN);
    assign slot_free = !wr_valid_o || wr_ready_i;

    // A pair is taken only when both an address and a result exist, so the FIFO never
    // pops without data; an abort cycle never fires.
    assign res_ready_o = running && !reset_cmd_i && slot_free && !addr_empty_i &&
                         (remaining_q != '0);
    assign fire        = res_ready_o && res_valid_i;
    assign addr_rden_o = fire;
    assign done_o      = (state_q == S_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            remaining_q <= '0;
        end else if (reset_cmd_i) begin
            state_q <= S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        remaining_q <= num_wb_i;
                        state_q     <= (num_wb_i == '0) ? S_DONE : S_RUN;
                    end
                end
                S_RUN: begin
                    if (fire) begin
                        remaining_q <= remaining_q - 1'b1;
                    end
                    if ((remaining_q == '0) && slot_free) begin
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    state_q <= S_DONE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    vpu_wb_out_reg #(
        .AW(OPERAND_ADDR_WIDTH),
        .DW(DATA_WIDTH)
    ) u_out_reg (
        .clk    (clk),
        .rst_n  (rst_n),
        .flush_i(reset_cmd_i),
        .load_i (fire),
        .addr_i (addr_rdata_i),
        .data_i (res_data_i),
        .ready_i(wr_ready_i),
        .valid_o(wr_valid_o),
        .addr_o (wr_addr_o),
        .data_o (wr_data_o)
    );

`ifdef VPU_WB_ISSUE_PERF_CNT_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((state_q == S_IDLE) && start_i && !reset_cmd_i) begin
            stall_cnt_d = '0;
        end else if (running && (remaining_q != '0) && !fire &&
                     (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`else
    assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_vpu_wb_issue.sv
// Randomised bench for vpu_wb_issue with a transaction-level reference model and scoreboard.
module tb_vpu_wb_issue;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start_i;
    logic [CW-1:0] num_wb_i;
    logic          reset_cmd_i;
    logic          done_o;
    logic          addr_empty_i;
    logic [AW-1:0] addr_rdata_i;
    logic          addr_rden_o;
    logic          res_valid_i;
    logic [DW-1:0] res_data_i;
    logic          res_ready_o;
    logic          wr_valid_o;
    logic [AW-1:0] wr_addr_o;
    logic [DW-1:0] wr_data_o;
    logic          wr_ready_i;
    logic [31:0]   stall_cnt_o;

    always #5 clk = ~clk;

    vpu_wb_issue dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start_i),
        .num_wb_i    (num_wb_i),
        .reset_cmd_i (reset_cmd_i),
        .done_o      (done_o),
        .addr_empty_i(addr_empty_i),
        .addr_rdata_i(addr_rdata_i),
        .addr_rden_o (addr_rden_o),
        .res_valid_i (res_valid_i),
        .res_data_i  (res_data_i),
        .res_ready_o (res_ready_o),
        .wr_valid_o  (wr_valid_o),
        .wr_addr_o   (wr_addr_o),
        .wr_data_o   (wr_data_o),
        .wr_ready_i  (wr_ready_i),
        .stall_cnt_o (stall_cnt_o)
    );

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;

    logic [AW+DW-1:0] exp_q[$];
    logic [AW-1:0]    aq[$];
    logic [AW-1:0]    bl_a[$];
    logic [DW-1:0]    dq[$];
    logic [AW+DW-1:0] acc_log[$];
    int               acc_cyc[$];
    int               done_cyc = -1;

    int            p_valid = 100;
    int            p_ready = 100;
    int            p_fifo = 100;
    logic [AW-1:0] stall_addr = '0;
    int            stall_left = 0;
    logic          req_start = 1'b0;
    logic          req_abort = 1'b0;
    logic [CW-1:0] req_num = '0;
    bit            chk_en = 1'b0;

    // reference model: 0 idle, 1 running, 2 done
    int               m_state = 0;
    int               m_rem = 0;
    bit               m_pend = 1'b0;
    logic [AW+DW-1:0] m_wr = '0;
    longint           m_stall = 0;

    bit               e_ready, e_fire, m_acc, m_fin;
    logic [AW-1:0]    cur_a;
    logic [DW-1:0]    cur_d;
    logic [AW+DW-1:0] sb_e;
    logic [63:0]      exp_stall;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic drive();
        if (bl_a.size() > 0 && $urandom_range(0, 99) < p_fifo) aq.push_back(bl_a.pop_front());
        addr_empty_i = (aq.size() == 0);
        if (aq.size() > 0) addr_rdata_i = aq[0];
        else addr_rdata_i = AW'($urandom);
        res_valid_i = (dq.size() > 0) && ($urandom_range(0, 99) < p_valid);
        if (dq.size() > 0) res_data_i = dq[0];
        else res_data_i = $urandom;
        wr_ready_i = ($urandom_range(0, 99) < p_ready);
        if (stall_left > 0 && wr_valid_o && wr_addr_o == stall_addr) begin
            wr_ready_i = 1'b0;
            stall_left--;
        end
        start_i     = req_start;
        num_wb_i    = req_num;
        reset_cmd_i = req_abort;
        req_start   = 1'b0;
        req_abort   = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic setup_cmd(input int num, input int extra, input bit preload, input bit rnd,
                             input logic [AW-1:0] abase, input logic [DW-1:0] dbase);
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        aq.delete(); bl_a.delete(); dq.delete(); exp_q.delete();
        acc_log.delete(); acc_cyc.delete();
        done_cyc = -1;
        for (int k = 0; k < num + extra; k++) begin
            a = rnd ? AW'($urandom) : abase + AW'(k);
            d = rnd ? DW'($urandom) : dbase + DW'(k);
            if (preload) aq.push_back(a);
            else bl_a.push_back(a);
            dq.push_back(d);
            if (k < num) exp_q.push_back({a, d});
        end
        req_num   = CW'(num);
        req_start = 1'b1;
    endtask

    task automatic wait_done(input int max_cyc);
        int n;
        n = 0;
        while (done_o !== 1'b1 && n < max_cyc) begin
            tick();
            n++;
        end
        if (done_o !== 1'b1) chk("done_timeout", 64'(done_o), 64'd1);
        @(negedge clk);
        #1;
    endtask

    task automatic finish_cmd();
        req_abort = 1'b1;
        tick();
        tick();
    endtask

    // Per-cycle comparison against the reference model, then advance the model.
    always @(negedge clk) begin
        if (chk_en) begin
            cyc++;
            cur_a   = addr_rdata_i;
            cur_d   = res_data_i;
            e_ready = (m_state == 1) && !reset_cmd_i && (!m_pend || wr_ready_i) &&
                      !addr_empty_i && (m_rem != 0);
            e_fire  = e_ready && res_valid_i;
            m_acc   = m_pend && wr_ready_i;
`ifdef VPU_WB_ISSUE_PERF_CNT_EN
            exp_stall = 64'(m_stall);
`else
            exp_stall = 64'd0;
`endif
            chk("done", 64'(done_o), 64'(m_state == 2));
            chk("res_ready", 64'(res_ready_o), 64'(e_ready));
            chk("addr_rden", 64'(addr_rden_o), 64'(e_fire));
            chk("wr_valid", 64'(wr_valid_o), 64'(m_pend));
            if (m_pend) chk("wr_pair", 64'({wr_addr_o, wr_data_o}), 64'(m_wr));
            chk("stall_cnt", 64'(stall_cnt_o), exp_stall);

            if (done_o && done_cyc < 0) done_cyc = cyc;
            if (wr_valid_o && wr_ready_i) begin
                if (exp_q.size() == 0) begin
                    chk("sb_extra_write", 64'd1, 64'd0);
                end else begin
                    sb_e = exp_q.pop_front();
                    chk("sb_write", 64'({wr_addr_o, wr_data_o}), 64'(sb_e));
                end
                acc_log.push_back({wr_addr_o, wr_data_o});
                acc_cyc.push_back(cyc);
            end
            if (addr_rden_o && aq.size() > 0) void'(aq.pop_front());
            if (res_ready_o && res_valid_i && dq.size() > 0) void'(dq.pop_front());

            if (m_state == 1 && m_rem != 0 && !e_fire && m_stall < 64'hFFFF_FFFF) m_stall++;
            if (reset_cmd_i) begin
                m_state = 0;
                m_pend  = 1'b0;
            end else if (m_state == 0) begin
                if (m_acc) m_pend = 1'b0;
                if (start_i) begin
                    m_rem   = int'(num_wb_i);
                    m_stall = 0;
                    m_state = (num_wb_i == 0) ? 2 : 1;
                end
            end else if (m_state == 1) begin
                m_fin = (m_rem == 0) && (!m_pend || wr_ready_i);
                if (e_fire) begin
                    m_pend = 1'b1;
                    m_wr   = {cur_a, cur_d};
                    m_rem--;
                end else if (m_acc) begin
                    m_pend = 1'b0;
                end
                if (m_fin) m_state = 2;
            end else begin
                if (m_acc) m_pend = 1'b0;
            end
        end
    end

    initial begin
        int num;
        rst_n = 1'b0;
        start_i = 1'b0; num_wb_i = '0; reset_cmd_i = 1'b0;
        addr_empty_i = 1'b1; addr_rdata_i = '0;
        res_valid_i = 1'b0; res_data_i = '0; wr_ready_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_done", 64'(done_o), 64'd0);
        chk("rst_wr_valid", 64'(wr_valid_o), 64'd0);
        chk("rst_rden", 64'(addr_rden_o), 64'd0);
        chk("rst_res_ready", 64'(res_ready_o), 64'd0);
        chk("rst_wr_addr", 64'(wr_addr_o), 64'd0);
        chk("rst_wr_data", 64'(wr_data_o), 64'd0);
        chk("rst_stall", 64'(stall_cnt_o), 64'd0);
        rst_n  = 1'b1;
        chk_en = 1'b1;
        tick();

        // Test 1: four back-to-back writes
        setup_cmd(4, 2, 1'b1, 1'b0, 10'h10, 32'hA0);
        wait_done(50);
        chk("t1_count", 64'(acc_log.size()), 64'd4);
        for (int k = 0; k < 4 && k < acc_log.size(); k++)
            chk("t1_pair", 64'(acc_log[k]), 64'({10'h10 + 10'(k), 32'hA0 + 32'(k)}));
        if (acc_log.size() == 4) begin
            chk("t1_consecutive", 64'(acc_cyc[3] - acc_cyc[0]), 64'd3);
            chk("t1_done_lat", 64'(done_cyc - acc_cyc[3]), 64'd1);
        end
        chk("t1_extras_left", 64'(aq.size()), 64'd2);
        finish_cmd();
        chk("t1_idle", 64'(done_o), 64'd0);

        // Test 2: three-cycle backpressure on the second write
        stall_addr = 10'h11;
        stall_left = 3;
        setup_cmd(4, 0, 1'b1, 1'b0, 10'h10, 32'hA0);
        wait_done(50);
        chk("t2_count", 64'(acc_log.size()), 64'd4);
        for (int k = 0; k < 4 && k < acc_log.size(); k++)
            chk("t2_pair", 64'(acc_log[k]), 64'({10'h10 + 10'(k), 32'hA0 + 32'(k)}));
        if (acc_log.size() == 4) begin
            chk("t2_stall_gap", 64'(acc_cyc[1] - acc_cyc[0]), 64'd4);
            chk("t2_span", 64'(acc_cyc[3] - acc_cyc[0]), 64'd6);
            chk("t2_done_lat", 64'(done_cyc - acc_cyc[3]), 64'd1);
        end
        finish_cmd();

        // Test 3: data valid while the address FIFO stays empty
        p_fifo = 0;
        setup_cmd(2, 0, 1'b0, 1'b0, 10'h40, 32'hB0);
        tick();
        for (int k = 0; k < 5; k++) begin
            tick();
            #1;
            chk("t3_res_ready", 64'(res_ready_o), 64'd0);
            chk("t3_rden", 64'(addr_rden_o), 64'd0);
        end
        p_fifo = 100;
        wait_done(50);
        chk("t3_count", 64'(acc_log.size()), 64'd2);
        finish_cmd();

        // Test 4: zero-length command
        setup_cmd(0, 1, 1'b1, 1'b0, 10'h50, 32'hC0);
        tick();
        tick();
        #1;
        chk("t4_done", 64'(done_o), 64'd1);
        chk("t4_no_write", 64'(wr_valid_o), 64'd0);
        req_abort = 1'b1;
        tick();
        tick();
        #1;
        chk("t4_idle", 64'(done_o), 64'd0);
        chk("t4_count", 64'(acc_log.size()), 64'd0);

        // Test 5: abort mid-command, then a fresh command
        setup_cmd(6, 0, 1'b1, 1'b0, 10'h60, 32'hD0);
        num = 0;
        while (acc_log.size() < 2 && num < 50) begin
            tick();
            num++;
        end
        reset_cmd_i = 1'b1;
        tick();
        #1;
        chk("t5_wr_valid", 64'(wr_valid_o), 64'd0);
        chk("t5_done", 64'(done_o), 64'd0);
        chk("t5_res_ready", 64'(res_ready_o), 64'd0);
        setup_cmd(3, 1, 1'b1, 1'b1, '0, '0);
        wait_done(50);
        chk("t5_restart_count", 64'(acc_log.size()), 64'd3);
        finish_cmd();

        // Test 6: seven pairing-stall cycles
        p_fifo = 0;
        setup_cmd(1, 0, 1'b0, 1'b0, 10'h70, 32'hE0);
        tick();
        repeat (7) tick();
        p_fifo = 100;
        wait_done(50);
`ifdef VPU_WB_ISSUE_PERF_CNT_EN
        chk("t6_stall_cnt", 64'(stall_cnt_o), 64'd7);
`else
        chk("t6_stall_cnt", 64'(stall_cnt_o), 64'd0);
`endif
        finish_cmd();

        // Randomised commands
        for (int t = 0; t < 30; t++) begin
            p_valid = $urandom_range(30, 100);
            p_ready = $urandom_range(30, 100);
            p_fifo  = $urandom_range(30, 100);
            num = $urandom_range(0, 12);
            setup_cmd(num, $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b1, '0, '0);
            wait_done(400);
            chk("rnd_count", 64'(acc_log.size()), 64'(num));
            chk("rnd_sb_empty", 64'(exp_q.size()), 64'd0);
            finish_cmd();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
